// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder
// Description : Turns a debounced button level into single-cycle event
//               pulses (press, release, short click, long press, double
//               click and, optionally, auto-repeat while long-held).
//               Optional feature macro: BTN_AUTOREPEAT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder #(
    parameter int CNTBW      = 8,
    parameter int LONG_CYC   = 200,
    parameter int DBL_CYC    = 50,
    parameter int REPEAT_CYC = 20
) (
    input  logic clk,
    input  logic rstn,
    input  logic lvl,
    output logic ev_press,
    output logic ev_release,
    output logic ev_short,
    output logic ev_long,
    output logic ev_double,
    output logic ev_repeat,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_LONG_HELD = 3'd2,
        S_WAIT2     = 3'd3,
        S_PRESSED2  = 3'd4
    } state_t;

    localparam logic [CNTBW-1:0] c_long_last = CNTBW'(LONG_CYC - 1);
    localparam logic [CNTBW-1:0] c_dbl_last  = CNTBW'(DBL_CYC - 1);
    localparam logic [CNTBW-1:0] c_cnt_max   = {CNTBW{1'b1}};
    localparam logic [CNTBW-1:0] c_cnt_one   = CNTBW'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNTBW-1:0]   r_cnt;
    logic [CNTBW-1:0]   w_cnt_nxt;
    logic [CNTBW-1:0]   w_cnt_inc;
    logic               r_lvl_d;
    logic               w_rise;
    logic               w_fall;

    logic               w_ev_press;
    logic               w_ev_release;
    logic               w_ev_short;
    logic               w_ev_long;
    logic               w_ev_double;
    logic               w_held_nxt;
    logic               w_busy_nxt;

    logic               r_ev_press;
    logic               r_ev_release;
    logic               r_ev_short;
    logic               r_ev_long;
    logic               r_ev_double;
    logic               r_held;
    logic               r_busy;

    assign w_rise    = lvl & ~r_lvl_d;
    assign w_fall    = ~lvl & r_lvl_d;
    // Shared timer saturates instead of wrapping.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    // Next-state and event decode; falls beat long detection, rises beat timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ev_press   = 1'b0;
        w_ev_release = 1'b0;
        w_ev_short   = 1'b0;
        w_ev_long    = 1'b0;
        w_ev_double  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A fall here is ignored: it is the release of a button held through reset.
                if (w_rise) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                    w_ev_press  = 1'b1;
                end
            end
            S_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt  = S_WAIT2;
                    w_cnt_nxt    = '0;
                    w_ev_release = 1'b1;
                end else if (r_cnt == c_long_last) begin
                    w_state_nxt = S_LONG_HELD;
                    w_cnt_nxt   = '0;
                    w_ev_long   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_LONG_HELD: begin
                if (w_fall) begin
                    w_state_nxt  = S_IDLE;
                    w_ev_release = 1'b1;
                end
            end
            S_WAIT2: begin
                if (w_rise) begin
                    w_state_nxt = S_PRESSED2;
                    w_ev_press  = 1'b1;
                    w_ev_double = 1'b1;
                end else if (r_cnt == c_dbl_last) begin
                    w_state_nxt = S_IDLE;
                    w_ev_short  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_PRESSED2: begin
                // No long detection on the second press of a double click.
                if (w_fall) begin
                    w_state_nxt  = S_IDLE;
                    w_ev_release = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_held_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_LONG_HELD) ||
                     (w_state_nxt == S_PRESSED2);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, timer and registered outputs; level history tracks lvl even in reset.
    always_ff @(posedge clk) begin
        r_lvl_d <= lvl;
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ev_press   <= 1'b0;
            r_ev_release <= 1'b0;
            r_ev_short   <= 1'b0;
            r_ev_long    <= 1'b0;
            r_ev_double  <= 1'b0;
            r_held       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ev_press   <= w_ev_press;
            r_ev_release <= w_ev_release;
            r_ev_short   <= w_ev_short;
            r_ev_long    <= w_ev_long;
            r_ev_double  <= w_ev_double;
            r_held       <= w_held_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign ev_press   = r_ev_press;
    assign ev_release = r_ev_release;
    assign ev_short   = r_ev_short;
    assign ev_long    = r_ev_long;
    assign ev_double  = r_ev_double;
    assign held       = r_held;
    assign busy       = r_busy;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNTBW-1:0] c_rep_last = CNTBW'(REPEAT_CYC - 1);

    logic [CNTBW-1:0]   r_rcnt;
    logic [CNTBW-1:0]   w_rcnt_nxt;
    logic               w_ev_repeat;
    logic               r_ev_repeat;

    // Repeat timer runs only in LONG_HELD and sits at zero elsewhere, so entry starts it cleared.
    always_comb begin
        w_rcnt_nxt  = r_rcnt;
        w_ev_repeat = 1'b0;
        if ((r_state != S_LONG_HELD) || w_fall) begin
            w_rcnt_nxt = '0;
        end else if (r_rcnt == c_rep_last) begin
            w_ev_repeat = 1'b1;
            w_rcnt_nxt  = '0;
        end else if (r_rcnt != c_cnt_max) begin
            w_rcnt_nxt = r_rcnt + c_cnt_one;
        end
    end

    // Repeat timer and registered repeat pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rcnt      <= '0;
            r_ev_repeat <= 1'b0;
        end else begin
            r_rcnt      <= w_rcnt_nxt;
            r_ev_repeat <= w_ev_repeat;
        end
    end

    assign ev_repeat = r_ev_repeat;
`else
    // Repeat period is meaningless without the feature; keep it referenced.
    logic w_unused_rep;
    assign w_unused_rep = ^CNTBW'(REPEAT_CYC);
    assign ev_repeat    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Scoreboard bench for button_event_decoder. Stimulus pushes
//               (decision edge, event vector) pairs; a negedge monitor pops
//               and compares whenever any event output is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int CNTBW      = 4;
    localparam int LONG_CYC   = 8;
    localparam int DBL_CYC    = 4;
    localparam int REPEAT_CYC = 3;

    // Event vector bit order: {press, release, short, long, double, repeat}
    localparam logic [5:0] E_PRESS = 6'b100000;
    localparam logic [5:0] E_REL   = 6'b010000;
    localparam logic [5:0] E_SHORT = 6'b001000;
    localparam logic [5:0] E_LONG  = 6'b000100;
    localparam logic [5:0] E_DBL   = 6'b000010;
    localparam logic [5:0] E_REP   = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] ev;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic lvl;
    logic ev_press, ev_release, ev_short, ev_long, ev_double, ev_repeat;
    logic held, busy;
    logic [5:0] w_ev;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   started = 1'b0;
    exp_t q[$];

    button_event_decoder #(
        .CNTBW      (CNTBW),
        .LONG_CYC   (LONG_CYC),
        .DBL_CYC    (DBL_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .lvl        (lvl),
        .ev_press   (ev_press),
        .ev_release (ev_release),
        .ev_short   (ev_short),
        .ev_long    (ev_long),
        .ev_double  (ev_double),
        .ev_repeat  (ev_repeat),
        .held       (held),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Counts posedges; after posedge N (plus a small delay) cyc equals N.
    always @(posedge clk) cyc <= cyc + 1;

    assign w_ev = {ev_press, ev_release, ev_short, ev_long, ev_double, ev_repeat};

    // Monitor: every cycle with an event must match the oldest expectation.
    always @(negedge clk) begin
        if (started && (w_ev !== 6'b0)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: cycle %0d got ev=%b, expected no event", cyc, w_ev);
            end else begin
                exp_t x;
                x = q.pop_front();
                if ((x.cyc != cyc) || (x.ev !== w_ev)) begin
                    n_err++;
                    $display("FAIL event_match: got ev=%b at cycle %0d, expected ev=%b at cycle %0d",
                             w_ev, cyc, x.ev, x.cyc);
                end
            end
        end
    end

    task automatic push(input int c, input logic [5:0] e);
        exp_t x;
        x.cyc = c;
        x.ev  = e;
        q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    initial begin
        int t;
        int r;
        rstn = 1'b0;
        lvl  = 1'b0;
        tick(3);
        chk("reset_events", w_ev, 6'b0);
        chk("reset_held",   {5'b0, held}, 6'b0);
        chk("reset_busy",   {5'b0, busy}, 6'b0);
        started = 1'b1;
        rstn = 1'b1;
        tick(2);

        // Short click: 3-cycle press, then nothing for the double window.
        t = cyc;
        lvl = 1'b1;
        push(t + 1, E_PRESS);
        tick(3);
        chk("short_held", {5'b0, held}, 6'b1);
        chk("short_busy", {5'b0, busy}, 6'b1);
        lvl = 1'b0;
        push(t + 4, E_REL);
        push(t + 8, E_SHORT);
        tick(10);
        chk("short_idle_busy", {5'b0, busy}, 6'b0);

        // Long press: held 16 cycles, long at press+8, repeats every 3 after.
        t = cyc;
        lvl = 1'b1;
        push(t + 1, E_PRESS);
        push(t + 9, E_LONG);
`ifdef BTN_AUTOREPEAT_EN
        push(t + 12, E_REP);
        push(t + 15, E_REP);
`endif
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            chk("long_held", {5'b0, held}, 6'b1);
        end
        lvl = 1'b0;
        push(t + 17, E_REL);
        tick(4);
        chk("long_after_held", {5'b0, held}, 6'b0);
        chk("long_after_busy", {5'b0, busy}, 6'b0);

        // Double click: 2 high, 2 low, 2 high.
        t = cyc;
        lvl = 1'b1;
        push(t + 1, E_PRESS);
        tick(2);
        lvl = 1'b0;
        push(t + 3, E_REL);
        tick(2);
        lvl = 1'b1;
        push(t + 5, E_PRESS | E_DBL);
        tick(2);
        chk("double_held", {5'b0, held}, 6'b1);
        lvl = 1'b0;
        push(t + 7, E_REL);
        tick(8);
        chk("double_idle_busy", {5'b0, busy}, 6'b0);

        // Boundary: second rise on the timeout edge (release+4) still counts as double.
        t = cyc;
        lvl = 1'b1;
        push(t + 1, E_PRESS);
        tick(2);
        lvl = 1'b0;
        r = t + 3;
        push(r, E_REL);
        tick(4);
        lvl = 1'b1;
        push(r + 4, E_PRESS | E_DBL);
        tick(2);
        lvl = 1'b0;
        push(t + 9, E_REL);
        tick(8);

        // Boundary: second rise one edge later -> short, then a fresh sequence.
        t = cyc;
        lvl = 1'b1;
        push(t + 1, E_PRESS);
        tick(2);
        lvl = 1'b0;
        r = t + 3;
        push(r, E_REL);
        tick(5);
        lvl = 1'b1;
        push(r + 4, E_SHORT);
        push(r + 5, E_PRESS);
        tick(2);
        lvl = 1'b0;
        push(t + 10, E_REL);
        push(t + 14, E_SHORT);
        tick(10);

        // Boundary: fall on the exact long edge -> release wins, short follows.
        t = cyc;
        lvl = 1'b1;
        push(t + 1, E_PRESS);
        tick(8);
        lvl = 1'b0;
        push(t + 9, E_REL);
        push(t + 13, E_SHORT);
        tick(10);

        // Reset while PRESSED with lvl held: no events afterwards, fall ignored.
        t = cyc;
        lvl = 1'b1;
        push(t + 1, E_PRESS);
        tick(3);
        rstn = 1'b0;
        tick(1);
        chk("rst_mid_events", w_ev, 6'b0);
        tick(1);
        chk("rst_mid_busy", {5'b0, busy}, 6'b0);
        chk("rst_mid_held", {5'b0, held}, 6'b0);
        rstn = 1'b1;
        tick(4);
        chk("rst_hold_busy", {5'b0, busy}, 6'b0);
        chk("rst_hold_held", {5'b0, held}, 6'b0);
        lvl = 1'b0;
        tick(4);
        chk("rst_fall_busy", {5'b0, busy}, 6'b0);
        tick(6);

        // Any expectation never consumed is a missed event.
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event: expected ev=%b at cycle %0d, never seen", x.ev, x.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
